// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO of {pc, instr} with a registered head so the
// outputs hold their last value when empty and never expose unwritten slots.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = head_q;
  assign count_o = cnt_q;

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      // New head is the word being written when it lands in the slot read next.
      if (cnt_d != '0)
        head_d = (do_push && (rd_d == wr_q)) ? din_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the fetch PC, checks ROM address legality, handles
// redirects and the sticky fault, and feeds the fetch buffer toward decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter  int          DEPTH     = 2,
  parameter  logic [63:0] MEM_BYTES = 64'd1024,
  parameter  logic [63:0] RESET_PC  = 64'd0,
  localparam int          CW        = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  logic [63:0]   fpc_q, fpc_d;
  logic          fault_q, fault_d;
  logic [64:0]   last_byte;
  logic          ok, pop, push, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head, din;

  // Last byte of the word must be inside the ROM; a carry out is illegal too.
  assign last_byte = {1'b0, fpc_q} + 65'd3;
  assign ok        = (fpc_q[1:0] == 2'b00) && !last_byte[64] && (last_byte[63:0] < MEM_BYTES);

  assign pop  = !empty && out_ready;
  assign push = !redirect_valid && !fault_q && ok && (!full || pop);
  assign din  = '{pc: fpc_q, instr: imem_instr};

  always_comb begin
    fpc_d   = fpc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      fpc_d = redirect_target;
    end else if (!fault_q && !ok) begin
      fault_d = 1'b1;
    end else if (push) begin
      fpc_d = fpc_q + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop && !redirect_valid),
    .flush_i (redirect_valid),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr = fpc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequences the instruction ROM for the single-cycle/pipelined ARM core. Owns the fetch program counter and drives the ROM's byte address. Buffers fetched {PC, instruction} pairs in a small FIFO toward decode with a valid/ready handshake. Handles branch redirects (flush plus new PC) and halts on out-of-range or misaligned fetch addresses before the ROM asserts.

## Interface
Parameters:
- DEPTH, 2: fetch buffer entries; must be a power of two and ≥ 1.
- MEM_BYTES, 1024: ROM size in bytes; must match the instruction ROM size.
- RESET_PC, 64'd0: fetch address after reset; word-aligned.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  byte address to the ROM; equals fetch PC `fpc`, combinational from the register.
- imem_instr  in  32  ROM read data for `imem_addr`, same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  64  new fetch byte address.
- out_valid  out  1  buffer head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at buffer head.
- out_pc  out  64  byte address of `out_instr`.
- fault  out  1  sticky; a bad fetch address was reached.

## Operation
- State:
  - `fpc` (64b).
  - FIFO of DEPTH entries, with read pointer, write pointer and count (width clog2(DEPTH)+1).
  - `fault` flag.
- Fetch legality: `ok = (fpc[1:0]==0) && (fpc + 3 < MEM_BYTES)`. Use unsigned 64-bit arithmetic; treat `fpc + 3` overflow as not ok.
- Pop: `pop = out_valid && out_ready`.
- Push: `push = !redirect_valid && !fault && ok && (count < DEPTH || pop)`.
  - On push, write {fpc, imem_instr} at the write pointer, then `fpc <= fpc + 4`.
- Fault set: `!redirect_valid && !fault && !ok`.
  - Sets `fault`; `fpc` holds. No push.
  - Entries already in the buffer still drain normally.
- Redirect takes priority over everything except reset:
  - Count, read pointer and write pointer go to 0.
  - `fpc <= redirect_target`.
  - Any same-cycle pop is discarded along with the flush.
  - No push that cycle.
- Redirect while faulted: `fpc` updates and the buffer flushes, but `fault` stays set and fetching stays halted. Only reset clears `fault`.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes negative.
- Full with simultaneous pop and push: count is unchanged and both pointers advance.
- Empty: `out_valid = 0`; `out_ready` is ignored. `out_instr` and `out_pc` hold the last head value (no X).
- `imem_instr` is sampled only when `push = 1`. X on it in other cycles must not propagate.

## Timing
- Reset values:
  - `fpc = RESET_PC`, so `imem_addr = RESET_PC`.
  - count = 0, `out_valid = 0`.
  - `out_instr = 0`, `out_pc = 0`, `fault = 0`.
- Reset mid-operation discards all buffered entries on that edge.
- Latency: a ROM word fetched in cycle N appears at the head in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction/cycle while `out_ready` stays high, for any DEPTH ≥ 1.
- Redirect asserted in cycle N:
  - `out_valid = 0` in cycle N+1.
  - `imem_addr = target` in cycle N+1.
  - First target entry is valid in cycle N+2.
- Fault: set at the edge ending the first cycle `fpc` is illegal; visible the next cycle.
- `out_*` and `fault` come from registers. `imem_addr` is register-driven with no combinational input path.

## Structure
- Package `fetch_pkg`:
  - `typedef struct packed {logic [63:0] pc; logic [31:0] instr;} fetch_entry_t`.
  - `localparam INSTR_BYTES = 4`.
- Sub-module `fetch_fifo #(DEPTH)`:
  - Stores `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, head, count.
- Top level holds `fpc`, the legality check, `fault` and the push/redirect priority logic.

## Test plan
- Reset, ROM word i = 32'h1000+i, `out_ready = 1` constant → `out_pc` 0,4,8,… with matching words on consecutive cycles; first valid one cycle after reset deasserts.
- `out_ready = 0` for 5 cycles → count saturates at DEPTH and `imem_addr` stalls at 4·DEPTH. Then raise `out_ready` → entries drain in order with no skip or duplicate.
- Redirect to 0x40 while the buffer is full and `out_ready = 1` → next cycle `out_valid = 0`; following cycle `out_pc = 0x40`; the popped head from the redirect cycle is not re-presented.
- Run sequentially to MEM_BYTES−4 → that entry is delivered, then `fault = 1` with `imem_addr` frozen at MEM_BYTES (1024) and no further `out_valid`.
- Redirect to 0x42 → `fault` rises one cycle later; a later redirect to 0x0 does not clear it; reset does, and fetch restarts at RESET_PC.
- Reset asserted with 2 buffered entries → `out_valid = 0` and all outputs at reset values on the next cycle.
